// File: rtl/ninjakun_shared_ram_arb.sv
// ninjakun_shared_ram_arb
//
// Shared-RAM responder for the two Z80s on the main board. A single-port
// RAM is time-shared between CPU0 and CPU1. A requesting CPU is held off
// with WAIT until its access has completed. When both CPUs request on the
// same edge, round-robin arbitration picks the winner. The block also holds
// one 8-bit mailbox per direction. A mailbox is loaded by a sync write and
// stays flagged to the other CPU until that CPU acknowledges it.
//
// Ports
//   CLK, RESET          clock; asynchronous active-high reset
//   CS_SHn, RDn, WRn    CPUn shared-RAM select and read/write strobes
//   ADn, DIn            CPUn address / write data
//   DOn                 CPUn read data (registered, held until next read)
//   WAITn               CPUn wait request (combinational)
//   SYNWRn              CPUn sync write level (loads mailbox on rising edge)
//   MB01, FLG01         CPU0->CPU1 mailbox data and unread flag
//   MB10, FLG10         CPU1->CPU0 mailbox data and unread flag
//   ACK1, ACK0          read acknowledge from CPU1 / CPU0; clears FLG01 / FLG10

module ninjakun_shared_ram_arb #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CS_SH0,
  input  logic          RD0,
  input  logic          WR0,
  input  logic [AW-1:0] AD0,
  input  logic [DW-1:0] DI0,
  output logic [DW-1:0] DO0,
  output logic          WAIT0,
  input  logic          CS_SH1,
  input  logic          RD1,
  input  logic          WR1,
  input  logic [AW-1:0] AD1,
  input  logic [DW-1:0] DI1,
  output logic [DW-1:0] DO1,
  output logic          WAIT1,
  input  logic          SYNWR0,
  input  logic          SYNWR1,
  output logic [DW-1:0] MB01,
  output logic [DW-1:0] MB10,
  output logic          FLG01,
  output logic          FLG10,
  input  logic          ACK1,
  input  logic          ACK0
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic          sel, sel_nxt;
  logic          pick;
  logic          last;
  logic          done0, done1;
  logic          active0, active1;
  logic          req0, req1;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_data;
  logic          lat_we;
  logic          acc_en;
  logic          ram_we;
  logic          fin0, fin1;
  logic          load0, load1;
  logic          syn0_q, syn1_q;
  logic          rise0, rise1;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  // A port is "active" for the whole bus cycle in which it has a strobe up.
  // done holds the port off after service until that bus cycle ends.
  assign active0 = CS_SH0 & (RD0 | WR0);
  assign active1 = CS_SH1 & (RD1 | WR1);
  assign req0    = active0 & ~done0;
  assign req1    = active1 & ~done1;

  // WAIT is forced low during reset so the CPUs are never stalled by a
  // request that the arbiter cannot serve.
  assign WAIT0 = req0 & ~RESET;
  assign WAIT1 = req1 & ~RESET;

  // FSM state register, together with the port selected for the access
  // that is in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
    end
  end

  // Next-state logic. On a tie, the port that was not served last wins, so
  // two CPUs that keep requesting are served alternately.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    pick      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0 && req1) begin
          sel_nxt = ~last;
          pick    = 1'b1;
        end else if (req0) begin
          sel_nxt = 1'b0;
          pick    = 1'b1;
        end else if (req1) begin
          sel_nxt = 1'b1;
          pick    = 1'b1;
        end
        if (pick) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode for the ACCESS cycle. A write always completes once it
  // has been latched. A read result, and the done flag, are only delivered
  // if the selected CPU still holds its bus cycle.
  always_comb begin
    acc_en = (state == ST_ACCESS);
    ram_we = acc_en & lat_we;
    fin0   = acc_en & ~sel & active0;
    fin1   = acc_en & sel & active1;
    load0  = fin0 & ~lat_we;
    load1  = fin1 & ~lat_we;
  end

  // Arbitration bookkeeping and the access latch. The latch captures the
  // winning port's address, data and direction on the pick edge. Having RD
  // and WR up together counts as a write.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last     <= 1'b1;
      done0    <= 1'b0;
      done1    <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_we   <= 1'b0;
    end else begin
      if (acc_en) last <= sel;
      done0 <= active0 & (done0 | fin0);
      done1 <= active1 & (done1 | fin1);
      if (pick) begin
        lat_addr <= sel_nxt ? AD1 : AD0;
        lat_data <= sel_nxt ? DI1 : DI0;
        lat_we   <= sel_nxt ? WR1 : WR0;
      end
    end
  end

  // Shared RAM storage. It is deliberately not reset, so its contents
  // survive a board reset. An access that is cut short by reset writes
  // nothing.
  always_ff @(posedge CLK) begin
    if (ram_we && !RESET) ram[lat_addr] <= lat_data;
  end

  // Read data registers. Each one keeps its last value until that port
  // completes another read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DO0 <= '0;
      DO1 <= '0;
    end else begin
      if (load0) DO0 <= ram[lat_addr];
      if (load1) DO1 <= ram[lat_addr];
    end
  end

  // Mailboxes. Each one is loaded on the registered rising edge of the sync
  // write level, so holding SYNWR high loads it only once. If a set and an
  // acknowledge land on the same edge, the set wins, so fresh data is never
  // lost.
  assign rise0 = SYNWR0 & ~syn0_q;
  assign rise1 = SYNWR1 & ~syn1_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      syn0_q <= 1'b0;
      syn1_q <= 1'b0;
      MB01   <= '0;
      MB10   <= '0;
      FLG01  <= 1'b0;
      FLG10  <= 1'b0;
    end else begin
      syn0_q <= SYNWR0;
      syn1_q <= SYNWR1;
      if (rise0) begin
        MB01  <= DI0;
        FLG01 <= 1'b1;
      end else if (ACK1) begin
        FLG01 <= 1'b0;
      end
      if (rise1) begin
        MB10  <= DI1;
        FLG10 <= 1'b1;
      end else if (ACK0) begin
        FLG10 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ninjakun_shared_ram_arb.sv
// tb_ninjakun_shared_ram_arb
//
// Cycle-vector bench for the shared-RAM arbiter. Each vector gives the
// inputs for one clock cycle and the outputs expected at the falling edge
// of that cycle. Inputs are driven just after the rising edge. Expected
// records are queued as they are driven and compared when the falling-edge
// checker pops them.

module tb_ninjakun_shared_ram_arb;

  typedef struct packed {
    logic [31:0] id;
    logic        rst;
    logic        cs0, rd0, wr0;
    logic [10:0] ad0;
    logic [7:0]  di0;
    logic        cs1, rd1, wr1;
    logic [10:0] ad1;
    logic [7:0]  di1;
    logic        syn0, syn1, ack0, ack1;
    logic        w0, w1;
    logic [7:0]  do0, do1, mb01, mb10;
    logic        f01, f10;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        CS_SH0 = 1'b0, RD0 = 1'b0, WR0 = 1'b0;
  logic [10:0] AD0 = '0;
  logic [7:0]  DI0 = '0;
  logic        CS_SH1 = 1'b0, RD1 = 1'b0, WR1 = 1'b0;
  logic [10:0] AD1 = '0;
  logic [7:0]  DI1 = '0;
  logic        SYNWR0 = 1'b0, SYNWR1 = 1'b0, ACK0 = 1'b0, ACK1 = 1'b0;
  logic [7:0]  DO0, DO1, MB01, MB10;
  logic        WAIT0, WAIT1, FLG01, FLG10;

  vec_t sb[$];
  vec_t exp_v;
  vec_t bus_tbl [37];
  int   n_vectors = 0;
  int   n_miscompares = 0;
  int   n_pushed = 0;

  always #5 CLK = ~CLK;

  ninjakun_shared_ram_arb #(.AW(11), .DW(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .CS_SH0(CS_SH0), .RD0(RD0), .WR0(WR0), .AD0(AD0), .DI0(DI0),
    .DO0(DO0), .WAIT0(WAIT0),
    .CS_SH1(CS_SH1), .RD1(RD1), .WR1(WR1), .AD1(AD1), .DI1(DI1),
    .DO1(DO1), .WAIT1(WAIT1),
    .SYNWR0(SYNWR0), .SYNWR1(SYNWR1),
    .MB01(MB01), .MB10(MB10), .FLG01(FLG01), .FLG10(FLG10),
    .ACK1(ACK1), .ACK0(ACK0)
  );

  // Bus-cycle vector with the mailbox lines idle and the mailboxes empty.
  function automatic vec_t bus_vec(input logic rst, cs0, rd0, wr0,
                                   input logic [10:0] ad0, input logic [7:0] di0,
                                   input logic cs1, rd1, wr1,
                                   input logic [10:0] ad1, input logic [7:0] di1,
                                   input logic w0, w1,
                                   input logic [7:0] do0, do1);
    vec_t v;
    v = '0;
    v.rst = rst;
    v.cs0 = cs0; v.rd0 = rd0; v.wr0 = wr0; v.ad0 = ad0; v.di0 = di0;
    v.cs1 = cs1; v.rd1 = rd1; v.wr1 = wr1; v.ad1 = ad1; v.di1 = di1;
    v.w0 = w0; v.w1 = w1; v.do0 = do0; v.do1 = do1;
    return v;
  endfunction

  // Mailbox-only vector. The read registers still hold the values left by
  // the bus sequence (port0 last read 0xC3, port1 last read 0x5A).
  function automatic vec_t mb_vec(input logic syn0, input logic [7:0] di0,
                                  input logic syn1, input logic [7:0] di1,
                                  input logic ack0, ack1,
                                  input logic f01, input logic [7:0] mb01,
                                  input logic f10, input logic [7:0] mb10);
    vec_t v;
    v = '0;
    v.syn0 = syn0; v.di0 = di0; v.syn1 = syn1; v.di1 = di1;
    v.ack0 = ack0; v.ack1 = ack1;
    v.do0 = 8'hC3; v.do1 = 8'h5A;
    v.f01 = f01; v.mb01 = mb01; v.f10 = f10; v.mb10 = mb10;
    return v;
  endfunction

  function automatic vec_t with_mb(input vec_t v, input logic f01,
                                   input logic [7:0] mb01, input logic f10,
                                   input logic [7:0] mb10);
    vec_t r;
    r = v;
    r.f01 = f01; r.mb01 = mb01; r.f10 = f10; r.mb10 = mb10;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(posedge CLK);
    #1;
    RESET  = v.rst;
    CS_SH0 = v.cs0; RD0 = v.rd0; WR0 = v.wr0; AD0 = v.ad0; DI0 = v.di0;
    CS_SH1 = v.cs1; RD1 = v.rd1; WR1 = v.wr1; AD1 = v.ad1; DI1 = v.di1;
    SYNWR0 = v.syn0; SYNWR1 = v.syn1; ACK0 = v.ack0; ACK1 = v.ack1;
    v.id = n_pushed;
    n_pushed++;
    sb.push_back(v);
  endtask

  task automatic cmp(input int id, input string nm, input logic [7:0] got,
                     input logic [7:0] want);
    if (got !== want) begin
      n_miscompares++;
      $display("[TB] FAIL vec %0d %s: got 0x%02h, expected 0x%02h", id, nm, got, want);
    end
  endtask

  task automatic checkOutput(input vec_t e);
    n_vectors++;
    cmp(e.id, "WAIT0", {7'b0, WAIT0}, {7'b0, e.w0});
    cmp(e.id, "WAIT1", {7'b0, WAIT1}, {7'b0, e.w1});
    cmp(e.id, "DO0",   DO0,           e.do0);
    cmp(e.id, "DO1",   DO1,           e.do1);
    cmp(e.id, "MB01",  MB01,          e.mb01);
    cmp(e.id, "MB10",  MB10,          e.mb10);
    cmp(e.id, "FLG01", {7'b0, FLG01}, {7'b0, e.f01});
    cmp(e.id, "FLG10", {7'b0, FLG10}, {7'b0, e.f10});
  endtask

  // Outputs are compared at the falling edge, away from the state update.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      checkOutput(exp_v);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: bench did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 RESET = 1'b1;

    //                 rst cs0 rd0 wr0 ad0      di0    cs1 rd1 wr1 ad1      di1    w0 w1 do0    do1
    // reset: a pending request must not raise WAIT while RESET is high
    bus_tbl[0]  = bus_vec(1, 1, 1, 0, 11'h123, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h00, 8'h00);
    bus_tbl[1]  = bus_vec(1, 0, 0, 0, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h00, 8'h00);
    bus_tbl[2]  = bus_vec(0, 0, 0, 0, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h00, 8'h00);
    // CPU0 write 0x123=0x5A, then read it back: two WAIT cycles each
    bus_tbl[3]  = bus_vec(0, 1, 0, 1, 11'h123, 8'h5A, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'h00, 8'h00);
    bus_tbl[4]  = bus_vec(0, 1, 0, 1, 11'h123, 8'h5A, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'h00, 8'h00);
    bus_tbl[5]  = bus_vec(0, 1, 0, 1, 11'h123, 8'h5A, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h00, 8'h00);
    bus_tbl[6]  = bus_vec(0, 0, 0, 0, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h00, 8'h00);
    bus_tbl[7]  = bus_vec(0, 1, 1, 0, 11'h123, 8'h00, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'h00, 8'h00);
    bus_tbl[8]  = bus_vec(0, 1, 1, 0, 11'h123, 8'h00, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'h00, 8'h00);
    bus_tbl[9]  = bus_vec(0, 1, 1, 0, 11'h123, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h5A, 8'h00);
    bus_tbl[10] = bus_vec(0, 0, 0, 0, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h5A, 8'h00);
    // reset again: read data clears, arbitration returns to "port0 first"
    bus_tbl[11] = bus_vec(1, 0, 0, 0, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h00, 8'h00);
    bus_tbl[12] = bus_vec(0, 0, 0, 0, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h00, 8'h00);
    // tie on reads of 0x123 (RAM survives reset): port0 waits 2, port1 waits 4
    bus_tbl[13] = bus_vec(0, 1, 1, 0, 11'h123, 8'h00, 1, 1, 0, 11'h123, 8'h00, 1, 1, 8'h00, 8'h00);
    bus_tbl[14] = bus_vec(0, 1, 1, 0, 11'h123, 8'h00, 1, 1, 0, 11'h123, 8'h00, 1, 1, 8'h00, 8'h00);
    bus_tbl[15] = bus_vec(0, 1, 1, 0, 11'h123, 8'h00, 1, 1, 0, 11'h123, 8'h00, 0, 1, 8'h5A, 8'h00);
    bus_tbl[16] = bus_vec(0, 1, 1, 0, 11'h123, 8'h00, 1, 1, 0, 11'h123, 8'h00, 0, 1, 8'h5A, 8'h00);
    bus_tbl[17] = bus_vec(0, 1, 1, 0, 11'h123, 8'h00, 1, 1, 0, 11'h123, 8'h00, 0, 0, 8'h5A, 8'h5A);
    bus_tbl[18] = bus_vec(0, 0, 0, 0, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h5A, 8'h5A);
    // CPU0 solo write 0x7FF=0x11 leaves port0 as last served
    bus_tbl[19] = bus_vec(0, 1, 0, 1, 11'h7FF, 8'h11, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'h5A, 8'h5A);
    bus_tbl[20] = bus_vec(0, 1, 0, 1, 11'h7FF, 8'h11, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'h5A, 8'h5A);
    bus_tbl[21] = bus_vec(0, 1, 0, 1, 11'h7FF, 8'h11, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h5A, 8'h5A);
    bus_tbl[22] = bus_vec(0, 0, 0, 0, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h5A, 8'h5A);
    // tie: CPU1 writes 0x7FF=0xC3 first, CPU0 then reads 0xC3 after 4 WAITs
    bus_tbl[23] = bus_vec(0, 1, 1, 0, 11'h7FF, 8'h00, 1, 0, 1, 11'h7FF, 8'hC3, 1, 1, 8'h5A, 8'h5A);
    bus_tbl[24] = bus_vec(0, 1, 1, 0, 11'h7FF, 8'h00, 1, 0, 1, 11'h7FF, 8'hC3, 1, 1, 8'h5A, 8'h5A);
    bus_tbl[25] = bus_vec(0, 1, 1, 0, 11'h7FF, 8'h00, 1, 0, 1, 11'h7FF, 8'hC3, 1, 0, 8'h5A, 8'h5A);
    bus_tbl[26] = bus_vec(0, 1, 1, 0, 11'h7FF, 8'h00, 1, 0, 1, 11'h7FF, 8'hC3, 1, 0, 8'h5A, 8'h5A);
    bus_tbl[27] = bus_vec(0, 1, 1, 0, 11'h7FF, 8'h00, 1, 0, 1, 11'h7FF, 8'hC3, 0, 0, 8'hC3, 8'h5A);
    bus_tbl[28] = bus_vec(0, 0, 0, 0, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'hC3, 8'h5A);
    // CS_SH0 held, strobe drops one cycle between two reads
    bus_tbl[29] = bus_vec(0, 1, 1, 0, 11'h123, 8'h00, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'hC3, 8'h5A);
    bus_tbl[30] = bus_vec(0, 1, 1, 0, 11'h123, 8'h00, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'hC3, 8'h5A);
    bus_tbl[31] = bus_vec(0, 1, 1, 0, 11'h123, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h5A, 8'h5A);
    bus_tbl[32] = bus_vec(0, 1, 0, 0, 11'h123, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h5A, 8'h5A);
    bus_tbl[33] = bus_vec(0, 1, 1, 0, 11'h7FF, 8'h00, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'h5A, 8'h5A);
    bus_tbl[34] = bus_vec(0, 1, 1, 0, 11'h7FF, 8'h00, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'h5A, 8'h5A);
    bus_tbl[35] = bus_vec(0, 1, 1, 0, 11'h7FF, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'hC3, 8'h5A);
    bus_tbl[36] = bus_vec(0, 0, 0, 0, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'hC3, 8'h5A);

    for (int i = 0; i < 37; i++) applyStimulus(bus_tbl[i]);

    // Mailbox CPU0->CPU1: SYNWR0 held 5 cycles loads 0x81 once; ACK1 clears.
    //                   syn0 di0    syn1 di1    ack0 ack1 f01 mb01   f10 mb10
    applyStimulus(mb_vec(1, 8'h81, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00));
    applyStimulus(mb_vec(1, 8'h81, 0, 8'h00, 0, 0, 1, 8'h81, 0, 8'h00));
    applyStimulus(mb_vec(1, 8'h81, 0, 8'h00, 0, 0, 1, 8'h81, 0, 8'h00));
    applyStimulus(mb_vec(1, 8'h55, 0, 8'h00, 0, 0, 1, 8'h81, 0, 8'h00));
    applyStimulus(mb_vec(1, 8'h55, 0, 8'h00, 0, 0, 1, 8'h81, 0, 8'h00));
    applyStimulus(mb_vec(0, 8'h00, 0, 8'h00, 0, 1, 1, 8'h81, 0, 8'h00));
    applyStimulus(mb_vec(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h81, 0, 8'h00));
    // reload, then ACK1 coincides with a new SYNWR0 edge: the set wins
    applyStimulus(mb_vec(1, 8'h3C, 0, 8'h00, 0, 0, 0, 8'h81, 0, 8'h00));
    applyStimulus(mb_vec(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h3C, 0, 8'h00));
    applyStimulus(mb_vec(1, 8'h96, 0, 8'h00, 0, 1, 1, 8'h3C, 0, 8'h00));
    applyStimulus(mb_vec(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h96, 0, 8'h00));
    // CPU1->CPU0 mailbox; ACK0 must leave FLG01 alone
    applyStimulus(mb_vec(0, 8'h00, 1, 8'hA7, 0, 0, 1, 8'h96, 0, 8'h00));
    applyStimulus(mb_vec(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h96, 1, 8'hA7));
    applyStimulus(mb_vec(0, 8'h00, 0, 8'h00, 1, 0, 1, 8'h96, 1, 8'hA7));
    applyStimulus(mb_vec(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h96, 0, 8'hA7));

    // Reset during the ACCESS of a write to 0x010: RAM keeps the old 0x24.
    applyStimulus(with_mb(bus_vec(0, 1, 0, 1, 11'h010, 8'h24, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'hC3, 8'h5A), 1, 8'h96, 0, 8'hA7));
    applyStimulus(with_mb(bus_vec(0, 1, 0, 1, 11'h010, 8'h24, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'hC3, 8'h5A), 1, 8'h96, 0, 8'hA7));
    applyStimulus(with_mb(bus_vec(0, 1, 0, 1, 11'h010, 8'h24, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'hC3, 8'h5A), 1, 8'h96, 0, 8'hA7));
    applyStimulus(with_mb(bus_vec(0, 0, 0, 0, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'hC3, 8'h5A), 1, 8'h96, 0, 8'hA7));
    applyStimulus(with_mb(bus_vec(0, 1, 0, 1, 11'h010, 8'hEE, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'hC3, 8'h5A), 1, 8'h96, 0, 8'hA7));
    applyStimulus(bus_vec(1, 1, 0, 1, 11'h010, 8'hEE, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h00, 8'h00));
    applyStimulus(bus_vec(0, 0, 0, 0, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h00, 8'h00));
    applyStimulus(bus_vec(0, 1, 1, 0, 11'h010, 8'h00, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'h00, 8'h00));
    applyStimulus(bus_vec(0, 1, 1, 0, 11'h010, 8'h00, 0, 0, 0, 11'h000, 8'h00, 1, 0, 8'h00, 8'h00));
    applyStimulus(bus_vec(0, 1, 1, 0, 11'h010, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h24, 8'h00));
    applyStimulus(bus_vec(0, 0, 0, 0, 11'h000, 8'h00, 0, 0, 0, 11'h000, 8'h00, 0, 0, 8'h24, 8'h00));

    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_miscompares++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
